shift_add_multiplier: RTL

Parametrised sequential two's-complement/unsigned multiplier: controller FSM, bit counter and datapath (A, B, X registers plus an add/sub unit) in one block. It generalises the 8-bit lab multiplier to any WIDTH, adds a per-operation signed/unsigned mode and exposes Busy/Done status. Its inputs are the board switch/button layer (debounced and synchronised upstream); its outputs drive the hex displays and LEDs.

---
 rtl/mult_pkg.sv | 19 +
 rtl/add_sub_w.sv | 31 +++
 rtl/shift_add_multiplier.sv | 106 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-add multiplier: controller states and
// the operation selected for the add/sub unit on each OP step.
`timescale 1ns/1ps
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OP,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_ADD,
    OP_SUB
  } op_sel_t;

endpackage

// File: rtl/add_sub_w.sv
// (WIDTH+1)-bit adder/subtractor; sign_ext chooses two's-complement or zero
// extension of both operands so the extra bit carries the sign or the carry-out.
`timescale 1ns/1ps
module add_sub_w
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign_ext,
  input  op_sel_t          op,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] ext_a;
  logic [WIDTH:0] ext_b;

  assign ext_a = {sign_ext & a[WIDTH-1], a};
  assign ext_b = {sign_ext & b[WIDTH-1], b};

  always_comb begin
    sum = ext_a;
    case (op)
      OP_ADD:  sum = ext_a + ext_b;
      OP_SUB:  sum = ext_a - ext_b;
      default: sum = ext_a;
    endcase
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential WIDTH x WIDTH multiplier: one OP/SHIFT pair per multiplier bit,
// product left in {Aval, Bval} with X as the sign/extension bit.
`timescale 1ns/1ps
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic             Signed_mode,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t          state;
  logic [CW-1:0]   count;
  logic            signed_op;
  op_sel_t         op_sel;
  logic [WIDTH:0]  sum;

  // In signed mode the multiplier's top bit has negative weight, so the last step subtracts.
  always_comb begin
    op_sel = OP_NONE;
    if (Bval[0]) begin
      op_sel = (signed_op && (count == LAST_STEP)) ? OP_SUB : OP_ADD;
    end
  end

  add_sub_w #(.WIDTH(WIDTH)) u_add_sub (
    .a        (Aval),
    .b        (S),
    .sign_ext (signed_op),
    .op       (op_sel),
    .sum      (sum)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      count     <= '0;
      signed_op <= 1'b0;
      Aval      <= '0;
      Bval      <= '0;
      X         <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Run) begin
            Aval      <= '0;
            X         <= 1'b0;
            count     <= '0;
            signed_op <= Signed_mode;
            Busy      <= 1'b1;
            state     <= OP;
          end else if (ClearA_LoadB) begin
            Aval <= '0;
            X    <= 1'b0;
            Bval <= S;
          end
        end
        OP: begin
          if (op_sel != OP_NONE) begin
            {X, Aval} <= sum;
          end
          state <= SHIFT;
        end
        SHIFT: begin
          Aval  <= {X, Aval[WIDTH-1:1]};
          Bval  <= {Aval[0], Bval[WIDTH-1:1]};
          if (!signed_op) begin
            X <= 1'b0;
          end
          count <= count + CW'(1);
          // Counter is about to reach WIDTH: this was the last pair.
          if (count == LAST_STEP) begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= OP;
          end
        end
        DONE: begin
          if (!Run) begin
            Done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
